// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared defaults and types for the single-clock FIFO, its
// interface and the surrounding environment.
//   DEFAULT_DATA_WIDTH - default stored word width
//   DEFAULT_DEPTH      - default number of entries (power of two, >= 2)
//   data_t             - one stored word at the default width
package sync_fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH      = 16;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: bundles the FIFO request/data/status signals.
//   wr, rd, clear, data_in          - driven by the user (master)
//   data_out, data_out_valid,
//   empty, full                     - driven by the FIFO (slave)
// clk and rst are kept as plain ports on the FIFO itself.
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    logic                  wr;
    logic                  rd;
    logic                  clear;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_valid;
    logic                  empty;
    logic                  full;

    modport master (
        output wr, rd, clear, data_in,
        input  data_out, data_out_valid, empty, full
    );

    modport slave (
        input  wr, rd, clear, data_in,
        output data_out, data_out_valid, empty, full
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x DATA_WIDTH register array with one synchronous write
// port and one registered read port.
//   clk, rst - clock, asynchronous active-high reset (read register only)
//   we, waddr, wdata - write port, stored on the rising edge when we=1
//   re, raddr        - read port, rdata loads mem[raddr] on the edge when re=1
//   rdata            - registered read data, holds when re=0
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage is not reset: the pointers/count decide what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, a read-valid strobe,
// synchronous flush and full/empty flags.
//   clk  - clock, all state changes on the rising edge
//   rst  - asynchronous active-high reset, clears all state
//   bus  - sync_fifo_if.slave: wr/rd/clear/data_in in,
//          data_out/data_out_valid/empty/full out
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input logic        clk,
    input logic        rst,
    sync_fifo_if.slave bus
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  valid_q;
    logic                  empty;
    logic                  full;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags come from the registered count, so they describe the state after
    // the last edge.
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);

    // clear wins over both requests in the same cycle.
    always_comb begin
        wr_acc = bus.wr && !full && !bus.clear;
        rd_acc = bus.rd && !empty && !bus.clear;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + (ADDR_WIDTH + 1)'(1);
                2'b01:   count_q <= count_q - (ADDR_WIDTH + 1)'(1);
                default: count_q <= count_q;
            endcase
            valid_q <= rd_acc;
        end
    end

    // data_out holds across clear because the read port only loads on rd_acc.
    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (bus.data_in),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (bus.data_out)
    );

    assign bus.data_out_valid = valid_q;
    assign bus.empty          = empty;
    assign bus.full           = full;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: self-checking bench for sync_fifo. A scoreboard queue holds
// the words the FIFO should contain; writes push, reads pop and compare.
module tb_sync_fifo;
    import sync_fifo_pkg::*;

    localparam int unsigned DEPTH = DEFAULT_DEPTH;

    logic clk;
    logic rst;

    sync_fifo_if bus ();

    sync_fifo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_t sb_q[$];
    data_t last_out;
    int    n_checks;
    int    n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle of stimulus with full output checking afterwards.
    task automatic cycle(input logic w, input logic r, input logic c, input data_t d);
        logic  wacc;
        logic  racc;
        data_t exp;
        int    occ;
        occ         = sb_q.size();
        bus.wr      = w;
        bus.rd      = r;
        bus.clear   = c;
        bus.data_in = d;
        wacc = w && !c && (occ < DEPTH);
        racc = r && !c && (occ > 0);
        @(posedge clk);
        #1;
        if (c) sb_q.delete();
        if (racc) begin
            exp = sb_q.pop_front();
            check_eq("rd_valid", bus.data_out_valid, 1);
            check_eq("rd_data", bus.data_out, exp);
            last_out = exp;
        end else begin
            check_eq("valid_low", bus.data_out_valid, 0);
            check_eq("data_hold", bus.data_out, last_out);
        end
        if (wacc) sb_q.push_back(d);
        check_eq("empty", bus.empty, (sb_q.size() == 0) ? 1 : 0);
        check_eq("full", bus.full, (sb_q.size() == DEPTH) ? 1 : 0);
        bus.wr    = 1'b0;
        bus.rd    = 1'b0;
        bus.clear = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        last_out    = '0;
        rst         = 1'b1;
        bus.wr      = 1'b0;
        bus.rd      = 1'b0;
        bus.clear   = 1'b0;
        bus.data_in = '0;

        // Reset then idle
        #7;
        check_eq("rst_empty", bus.empty, 1);
        check_eq("rst_full", bus.full, 0);
        check_eq("rst_data", bus.data_out, 0);
        check_eq("rst_valid", bus.data_out_valid, 0);
        #5;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // Fill, dropped overflow write, drain
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, data_t'(i));
        cycle(1'b1, 1'b0, 1'b0, 8'hAA);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // Reads while empty are ignored
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);

        // wr+rd while empty: only the write lands
        cycle(1'b1, 1'b1, 1'b0, 8'h99);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);

        // Concurrent access with 3 words held
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, data_t'(8'h30 + i));
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, data_t'(8'h40 + i));
        check_eq("conc_count", 32'(dut.count_q), 3);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);

        // wr+rd while full: only the read lands
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, data_t'(8'h60 + i));
        cycle(1'b1, 1'b1, 1'b0, 8'hBB);
        check_eq("full_rw_count", 32'(dut.count_q), 15);
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);

        // Wrap-around
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, data_t'(8'h50 + i));
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, data_t'(8'h80 + i));
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);

        // Clear mid-stream with wr held high
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, data_t'(8'hD0 + i));
        cycle(1'b1, 1'b0, 1'b1, 8'hE0);
        cycle(1'b1, 1'b0, 1'b1, 8'hE1);
        cycle(1'b1, 1'b0, 1'b0, 8'hC7);
        cycle(1'b1, 1'b0, 1'b0, 8'hC8);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // Asynchronous reset mid-stream kills an in-flight valid pulse
        cycle(1'b1, 1'b0, 1'b0, 8'h11);
        cycle(1'b1, 1'b0, 1'b0, 8'h22);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        rst = 1'b1;
        #1;
        check_eq("arst_valid", bus.data_out_valid, 0);
        check_eq("arst_data", bus.data_out, 0);
        check_eq("arst_empty", bus.empty, 1);
        check_eq("arst_full", bus.full, 0);
        sb_q.delete();
        last_out = '0;
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 8'h33);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
